// File: rtl/rob_param_if.sv
// Entry packet type plus the dispatch / completion / retire bundle of the
// parametrised reorder buffer. The package sits in this file so the entry
// type is available wherever the interface is.
package rob_param_pkg;
   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;                 // instruction address
      logic [XLEN-1:0] npc;                // fall-through address
      logic [XLEN-1:0] predict_pc;         // predicted target when predicted taken
      logic [XLEN-1:0] target_pc;          // redirect address on mispredict
      logic [XLEN-1:0] res_target;         // resolved branch target
      logic            is_branch;
      logic            is_store;
      logic            predict_taken;
      logic            taken;              // resolved direction
      logic            completed;
      logic            precise_state_need; // entry mispredicted, flush on retire
   } rob_entry_t;
endpackage

interface rob_param_if #(
   parameter int DEPTH  = 32,
   parameter int DISP_W = 3,
   parameter int CMPL_W = 3,
   parameter int RET_W  = 3
) ();
   import rob_param_pkg::*;

   localparam int IDX = $clog2(DEPTH);
   localparam int CW  = $clog2(RET_W + 1);

   logic [DISP_W-1:0]                disp_valid;
   rob_entry_t [DISP_W-1:0]          disp_entry;
   logic [DISP_W-1:0]                disp_accept;
   logic [DISP_W-1:0][IDX-1:0]       disp_idx;
   logic [IDX:0]                     free_slots;

   logic [CMPL_W-1:0]                cmpl_valid;
   logic [CMPL_W-1:0][IDX-1:0]       cmpl_idx;
   logic [CMPL_W-1:0]                cmpl_taken;
   logic [CMPL_W-1:0][XLEN-1:0]      cmpl_target;
   logic [CW-1:0]                    sq_credit;

   logic [RET_W-1:0]                 retire_valid;
   rob_entry_t [RET_W-1:0]           retire_entry;
   logic                             flush_en;
   logic [XLEN-1:0]                  flush_pc;
   logic                             update_EN;
   logic [XLEN-1:0]                  update_pc;
   logic                             update_direction;
   logic [XLEN-1:0]                  update_target;
   logic [IDX:0]                     occupancy;

   // Front end / execution / retire side
   modport master (
      output disp_valid, disp_entry, cmpl_valid, cmpl_idx, cmpl_taken, cmpl_target, sq_credit,
      input  disp_accept, disp_idx, free_slots, retire_valid, retire_entry, flush_en, flush_pc,
             update_EN, update_pc, update_direction, update_target, occupancy
   );

   // Reorder buffer side
   modport slave (
      input  disp_valid, disp_entry, cmpl_valid, cmpl_idx, cmpl_taken, cmpl_target, sq_credit,
      output disp_accept, disp_idx, free_slots, retire_valid, retire_entry, flush_en, flush_pc,
             update_EN, update_pc, update_direction, update_target, occupancy
   );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order dispatch into a circular array,
// out-of-order completion, in-order retire gated by store-queue credits,
// and a self-generated precise flush when a mispredicted branch retires.
module rob_param
   import rob_param_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int DISP_W = 3,
   parameter int CMPL_W = 3,
   parameter int RET_W  = 3
) (
   input  logic      clock,
   input  logic      reset,
   rob_param_if.slave bus
);
   localparam int IDX = $clog2(DEPTH);

   rob_entry_t              r_entries [DEPTH];
   logic [DEPTH-1:0]        r_valid;
   logic [IDX-1:0]          r_head;
   logic [IDX-1:0]          r_tail;
   logic [IDX:0]            r_occ;

   logic [IDX:0]            w_free;
   logic [DISP_W-1:0]       w_pref;
   logic [DISP_W-1:0]       w_acc;
   logic [DISP_W-1:0][IDX-1:0] w_disp_idx;
   rob_entry_t [DISP_W-1:0] w_disp_ent;
   logic [IDX:0]            w_acc_cnt;

   logic [CMPL_W-1:0]       w_mis;
   logic [CMPL_W-1:0][XLEN-1:0] w_mis_tgt;

   logic [RET_W-1:0]        w_ret;
   rob_entry_t [RET_W-1:0]  w_ret_ent;
   logic [IDX:0]            w_ret_cnt;
   logic                    w_flush;
   logic [XLEN-1:0]         w_flush_pc;
   logic                    w_upd_en;
   logic [XLEN-1:0]         w_upd_pc;
   logic                    w_upd_dir;
   logic [XLEN-1:0]         w_upd_tgt;

   // Free space comes only from registered occupancy, so same-cycle retires
   // never feed the dispatch acceptance path.
   assign w_free = (IDX+1)'(DEPTH) - r_occ;

   genvar gi;
   generate
      for (gi = 0; gi < DISP_W; gi++) begin : g_disp
         if (gi == 0) begin : g_first
            assign w_pref[gi] = bus.disp_valid[gi];
         end else begin : g_rest
            assign w_pref[gi] = w_pref[gi-1] & bus.disp_valid[gi];
         end
         assign w_acc[gi]      = w_pref[gi] & ~reset & (w_free > (IDX+1)'(gi));
         assign w_disp_idx[gi] = w_acc[gi] ? (r_tail + IDX'(gi)) : '0;
      end
   endgenerate

   // Accepted-lane count and dispatched entries with status bits cleared
   always_comb begin
      w_acc_cnt  = '0;
      w_disp_ent = bus.disp_entry;
      for (int i = 0; i < DISP_W; i++) begin
         w_disp_ent[i].completed          = 1'b0;
         w_disp_ent[i].precise_state_need = 1'b0;
         if (w_acc[i]) w_acc_cnt = w_acc_cnt + (IDX+1)'(1);
      end
   end

   // Mispredict detection per completion port against the stored prediction
   always_comb begin
      w_mis     = '0;
      w_mis_tgt = '0;
      for (int p = 0; p < CMPL_W; p++) begin
         if (r_entries[bus.cmpl_idx[p]].is_branch) begin
            if (!r_entries[bus.cmpl_idx[p]].predict_taken && bus.cmpl_taken[p]) begin
               w_mis[p]     = 1'b1;
               w_mis_tgt[p] = bus.cmpl_target[p];
            end else if (r_entries[bus.cmpl_idx[p]].predict_taken && !bus.cmpl_taken[p]) begin
               w_mis[p]     = 1'b1;
               w_mis_tgt[p] = r_entries[bus.cmpl_idx[p]].npc;
            end else if (bus.cmpl_taken[p] &&
                         (bus.cmpl_target[p] != r_entries[bus.cmpl_idx[p]].predict_pc)) begin
               w_mis[p]     = 1'b1;
               w_mis_tgt[p] = bus.cmpl_target[p];
            end
         end
      end
   end

   // In-order retire scan from head; a mispredicted entry retires and blocks the rest
   always_comb begin : p_retire
      logic           blocked;
      logic           upd_found;
      int             stores;
      logic [IDX-1:0] idx;
      rob_entry_t     e;
      blocked    = 1'b0;
      upd_found  = 1'b0;
      stores     = 0;
      idx        = '0;
      e          = '0;
      w_ret      = '0;
      w_ret_ent  = '0;
      w_ret_cnt  = '0;
      w_flush    = 1'b0;
      w_flush_pc = '0;
      w_upd_en   = 1'b0;
      w_upd_pc   = '0;
      w_upd_dir  = 1'b0;
      w_upd_tgt  = '0;
      for (int k = 0; k < RET_W; k++) begin
         idx = r_head + IDX'(k);
         e   = r_entries[idx];
         if (!blocked && (k < int'(r_occ)) && r_valid[idx] && e.completed &&
             (!e.is_store || (stores < int'(bus.sq_credit)))) begin
            w_ret[k]     = 1'b1;
            w_ret_ent[k] = e;
            w_ret_cnt    = w_ret_cnt + (IDX+1)'(1);
            if (e.is_store) stores++;
            if (e.is_branch && !upd_found) begin
               upd_found = 1'b1;
               w_upd_en  = 1'b1;
               w_upd_pc  = e.pc;
               w_upd_dir = e.taken;
               w_upd_tgt = e.res_target;
            end
            if (e.precise_state_need) begin
               blocked    = 1'b1;
               w_flush    = 1'b1;
               w_flush_pc = e.target_pc;
            end
         end else begin
            blocked = 1'b1;
         end
      end
   end

   assign bus.disp_accept      = w_acc;
   assign bus.disp_idx         = w_disp_idx;
   assign bus.free_slots       = w_free;
   assign bus.occupancy        = r_occ;
   assign bus.retire_valid     = w_ret;
   assign bus.retire_entry     = w_ret_ent;
   assign bus.flush_en         = w_flush;
   assign bus.flush_pc         = w_flush_pc;
   assign bus.update_EN        = w_upd_en;
   assign bus.update_pc        = w_upd_pc;
   assign bus.update_direction = w_upd_dir;
   assign bus.update_target    = w_upd_tgt;

   // Entry array and pointer update; reset and flush both empty the buffer
   always_ff @(posedge clock) begin
      if (reset || w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_occ   <= '0;
         r_valid <= '0;
         for (int d = 0; d < DEPTH; d++) r_entries[d] <= '0;
      end else begin
         // Later ports overwrite earlier ones, so the highest port wins
         for (int p = 0; p < CMPL_W; p++) begin
            if (bus.cmpl_valid[p] && r_valid[bus.cmpl_idx[p]]) begin
               r_entries[bus.cmpl_idx[p]].completed          <= 1'b1;
               r_entries[bus.cmpl_idx[p]].taken              <= bus.cmpl_taken[p];
               r_entries[bus.cmpl_idx[p]].res_target         <= bus.cmpl_target[p];
               r_entries[bus.cmpl_idx[p]].precise_state_need <= w_mis[p];
               if (w_mis[p]) r_entries[bus.cmpl_idx[p]].target_pc <= w_mis_tgt[p];
            end
         end
         for (int k = 0; k < RET_W; k++) begin
            if (w_ret[k]) begin
               r_entries[r_head + IDX'(k)] <= '0;
               r_valid[r_head + IDX'(k)]   <= 1'b0;
            end
         end
         for (int i = 0; i < DISP_W; i++) begin
            if (w_acc[i]) begin
               r_entries[r_tail + IDX'(i)] <= w_disp_ent[i];
               r_valid[r_tail + IDX'(i)]   <= 1'b1;
            end
         end
         r_head <= r_head + w_ret_cnt[IDX-1:0];
         r_tail <= r_tail + w_acc_cnt[IDX-1:0];
         r_occ  <= r_occ + w_acc_cnt - w_ret_cnt;
      end
   end
endmodule
